// File: rtl/seg_adder_sequencer_if.sv
// Operand/result handshake bundle for the segmented adder sequencer.
// The master drives operands and result acceptance; the slave is the adder.
interface seg_adder_sequencer_if #(
  parameter int N = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout, busy
  );
endinterface

// File: rtl/seg_adder_sequencer.sv
// N-bit adder built from one SEG-bit slice reused over N/SEG cycles.
// Carry ripples between segments through a register; operands and result use valid/ready.
module seg_adder_sequencer #(
  parameter int N   = 24,
  parameter int SEG = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_adder_sequencer_if.slave  bus
);
  localparam int NSEG  = N / SEG;
  localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [N-1:0]       r_s;
  logic               r_carry;
  logic               r_cout;
  logic [IDX_W-1:0]   r_seg_idx;

  logic [31:0]        w_shift;
  logic [SEG-1:0]     w_a_slice;
  logic [SEG-1:0]     w_b_slice;
  logic [SEG-1:0]     w_sum;
  logic               w_c;
  logic [N-1:0]       w_mask;
  logic [N-1:0]       w_sum_pos;
  logic               w_last;
  logic               w_accept;
  logic               w_handoff;

  function automatic logic [SEG:0] slice_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  // Slice selection by shifting keeps every select index at its natural width.
  assign w_shift   = 32'(r_seg_idx) * 32'(SEG);
  assign w_a_slice = SEG'(r_a >> w_shift);
  assign w_b_slice = SEG'(r_b >> w_shift);
  assign {w_c, w_sum} = slice_add(w_a_slice, w_b_slice, r_carry);
  assign w_mask    = N'({SEG{1'b1}}) << w_shift;
  assign w_sum_pos = N'(w_sum) << w_shift;

  assign w_last    = (r_seg_idx == IDX_W'(NSEG - 1));
  assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
  assign w_handoff = (r_state == S_DONE) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (w_handoff) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE:  bus.in_ready = 1'b1;
      S_RUN:   bus.busy = 1'b1;
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Datapath: capture on acceptance, then one slice per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_s       <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_seg_idx <= '0;
    end else if (w_accept) begin
      r_a       <= bus.a;
      r_b       <= bus.b;
      r_carry   <= bus.cin;
      r_seg_idx <= '0;
    end else if (r_state == S_RUN) begin
      r_s     <= (r_s & ~w_mask) | w_sum_pos;
      r_carry <= w_c;
      if (w_last) begin
        r_cout    <= w_c;
        r_seg_idx <= '0;
      end else begin
        r_seg_idx <= r_seg_idx + IDX_W'(1);
      end
    end
  end

  assign bus.s    = r_s;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_seg_adder_sequencer.sv
// Bench for seg_adder_sequencer: SEG=6, SEG=24 and SEG=1 builds of a 24-bit adder,
// directed corner cases plus random operands against a plain-arithmetic sum model.
module tb_seg_adder_sequencer;
  localparam int N = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int nseg_of [3] = '{4, 1, 24};

  logic         in_valid_v  [3];
  logic [N-1:0] a_v         [3];
  logic [N-1:0] b_v         [3];
  logic         cin_v       [3];
  logic         out_ready_v [3];
  logic         in_ready_v  [3];
  logic         out_valid_v [3];
  logic [N-1:0] s_v         [3];
  logic         cout_v      [3];
  logic         busy_v      [3];

  seg_adder_sequencer_if #(.N(N)) bus0 ();
  seg_adder_sequencer_if #(.N(N)) bus1 ();
  seg_adder_sequencer_if #(.N(N)) bus2 ();

  assign bus0.in_valid = in_valid_v[0];  assign bus1.in_valid = in_valid_v[1];  assign bus2.in_valid = in_valid_v[2];
  assign bus0.a = a_v[0];                assign bus1.a = a_v[1];                assign bus2.a = a_v[2];
  assign bus0.b = b_v[0];                assign bus1.b = b_v[1];                assign bus2.b = b_v[2];
  assign bus0.cin = cin_v[0];            assign bus1.cin = cin_v[1];            assign bus2.cin = cin_v[2];
  assign bus0.out_ready = out_ready_v[0]; assign bus1.out_ready = out_ready_v[1]; assign bus2.out_ready = out_ready_v[2];
  assign in_ready_v[0] = bus0.in_ready;  assign in_ready_v[1] = bus1.in_ready;  assign in_ready_v[2] = bus2.in_ready;
  assign out_valid_v[0] = bus0.out_valid; assign out_valid_v[1] = bus1.out_valid; assign out_valid_v[2] = bus2.out_valid;
  assign s_v[0] = bus0.s;                assign s_v[1] = bus1.s;                assign s_v[2] = bus2.s;
  assign cout_v[0] = bus0.cout;          assign cout_v[1] = bus1.cout;          assign cout_v[2] = bus2.cout;
  assign busy_v[0] = bus0.busy;          assign busy_v[1] = bus1.busy;          assign busy_v[2] = bus2.busy;

  seg_adder_sequencer #(.N(N), .SEG(6))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  seg_adder_sequencer #(.N(N), .SEG(24)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  seg_adder_sequencer #(.N(N), .SEG(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic logic [N:0] ref_sum(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + (N+1)'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands, accept them, scramble the inputs, and check latency and result.
  task automatic start_op(input int k, input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0] exp;
    int n;
    exp = ref_sum(x, y, c);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready_v[k]), 32'd1);
    in_valid_v[k] = 1'b1;
    a_v[k] = x; b_v[k] = y; cin_v[k] = c;
    @(posedge clk);
    #1;
    in_valid_v[k] = 1'b0;
    a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0;
    n = 0;
    while (out_valid_v[k] !== 1'b1 && n < nseg_of[k] + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(nseg_of[k]));
    chk("sum", 32'(s_v[k]), 32'(exp[N-1:0]));
    chk("cout", 32'(cout_v[k]), 32'(exp[N]));
    chk("in_ready_done", 32'(in_ready_v[k]), 32'd0);
    chk("busy_done", 32'(busy_v[k]), 32'd1);
  endtask

  task automatic handoff(input int k, input logic [N:0] exp);
    out_ready_v[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[k] = 1'b0;
    chk("out_valid_after", 32'(out_valid_v[k]), 32'd0);
    chk("in_ready_after", 32'(in_ready_v[k]), 32'd1);
    chk("busy_after", 32'(busy_v[k]), 32'd0);
    chk("sum_retained", 32'({cout_v[k], s_v[k]}), 32'(exp));
  endtask

  initial begin
    logic [N:0] exp;
    logic [N-1:0] ra, rb;
    logic rc;
    logic [N:0] q[$];
    int last;
    int n;

    for (int k = 0; k < 3; k++) begin
      in_valid_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0; out_ready_v[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
    chk("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("rst_sum", 32'({cout_v[0], s_v[0]}), 32'd0);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    start_op(0, 24'hFFFFFF, 24'h000001, 1'b0);
    handoff(0, {1'b1, 24'h000000});
    start_op(0, 24'h123456, 24'h654321, 1'b1);
    chk("sum_const_777778", 32'(s_v[0]), 32'h777778);
    handoff(0, {1'b0, 24'h777778});
    start_op(0, 24'h00003F, 24'h000000, 1'b1);
    handoff(0, {1'b0, 24'h000040});
    start_op(0, 24'h800000, 24'h800000, 1'b0);
    handoff(0, {1'b1, 24'h000000});

    // Backpressure: result must hold while in_valid is asserted in DONE.
    start_op(0, 24'hABCDEF, 24'h111111, 1'b1);
    exp = ref_sum(24'hABCDEF, 24'h111111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid_v[0] = 1'b1;
      a_v[0] = 24'($urandom); b_v[0] = 24'($urandom); cin_v[0] = 1'($urandom);
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid_v[0]), 32'd1);
      chk("bp_result", 32'({cout_v[0], s_v[0]}), 32'(exp));
      chk("bp_in_ready", 32'(in_ready_v[0]), 32'd0);
    end
    in_valid_v[0] = 1'b0;
    handoff(0, exp);

    // Back-to-back with both handshakes held high.
    @(negedge clk);
    out_ready_v[0] = 1'b1;
    in_valid_v[0]  = 1'b1;
    last = -1;
    for (int cyc = 0; cyc < 62; cyc++) begin
      if (out_valid_v[0] === 1'b1) begin
        if (q.size() == 0) begin
          chk("b2b_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp = q.pop_front();
          chk("b2b_result", 32'({cout_v[0], s_v[0]}), 32'(exp));
        end
        if (last >= 0) chk("b2b_interval", 32'(cyc - last), 32'd6);
        last = cyc;
      end
      ra = 24'($urandom); rb = 24'($urandom); rc = 1'($urandom);
      a_v[0] = ra; b_v[0] = rb; cin_v[0] = rc;
      if (in_ready_v[0] === 1'b1) q.push_back(ref_sum(ra, rb, rc));
      @(posedge clk);
      #1;
    end
    in_valid_v[0] = 1'b0;
    n = 0;
    while (busy_v[0] !== 1'b0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_drain", 32'(busy_v[0]), 32'd0);
    out_ready_v[0] = 1'b0;

    // Reset after two segments of a run.
    @(negedge clk);
    in_valid_v[0] = 1'b1; a_v[0] = 24'hFFFFFF; b_v[0] = 24'hFFFFFF; cin_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrun_in_ready", 32'(in_ready_v[0]), 32'd1);
    chk("midrun_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("midrun_sum", 32'({cout_v[0], s_v[0]}), 32'd0);
    chk("midrun_busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op(0, 24'h000010, 24'h000020, 1'b0);
    handoff(0, {1'b0, 24'h000030});

    // Random operands on the single-cycle and 24-cycle builds.
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = (i % 17 == 0) ? 24'hFFFFFF : 24'($urandom);
        rb = (i % 13 == 0) ? 24'hFFFFFF - ra : 24'($urandom);
        rc = 1'($urandom);
        start_op(k, ra, rb, rc);
        handoff(k, ref_sum(ra, rb, rc));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seg_adder_sequencer.md
Name: seg_adder_sequencer

Overview:
Multi-cycle adder controller. It reuses one SEG-bit adder slice over NSEG = N/SEG clock cycles to form an N-bit sum a+b+cin. The carry is held in a register between segments. The block sits where a full-width carry-lookahead or carry-select adder costs too much area, and exchanges operands and results with its neighbours over valid/ready handshakes.

Parameters:
N, 24, total operand width in bits; must be a multiple of SEG.
SEG, 6, width of the shared adder slice; SEG >= 1.
NSEG, N/SEG, derived segment count; not overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand request.
in_ready  output  1  block can accept operands.
a  input  N  operand A, sampled on acceptance.
b  input  N  operand B, sampled on acceptance.
cin  input  1  carry-in, sampled on acceptance.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
s  output  N  sum.
cout  output  1  carry-out of bit N-1.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, seg_idx=0, carry_reg=0, a_reg=b_reg=0, s=0, cout=0, out_valid=0, in_ready=1, busy=0. Reset dominates all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a clock edge (the acceptance edge): capture a, b, cin into a_reg, b_reg, carry_reg; set seg_idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: {c, sum} = a_reg[seg_idx*SEG +: SEG] + b_reg[same slice] + carry_reg, computed at SEG+1 bits.
  - Write sum into s[seg_idx*SEG +: SEG]; carry_reg <= c; seg_idx++.
  - On the edge that processes seg_idx = NSEG-1: cout <= c, seg_idx <= 0, go to DONE with out_valid=1.
- Latency: out_valid rises exactly NSEG edges after the acceptance edge. With N=24, SEG=6 this is 4. With NSEG=1 it is 1 (a single RUN cycle).
- DONE:
  - out_valid=1; s and cout held stable.
  - On out_valid & out_ready at an edge: out_valid <= 0, go to IDLE.
  - in_valid is ignored in DONE and RUN; no overlap of operations.
- Throughput: one result per NSEG+2 cycles (IDLE, NSEG RUN cycles, DONE) with in_valid and out_ready held high.
- s during RUN is partially updated slice by slice. It is only meaningful while out_valid=1.
- After handoff, s and cout retain the last result until the next RUN overwrites them.
- Operand changes on a, b, cin after acceptance have no effect.
- Arithmetic: result modulo 2^N; cout is bit N of a+b+cin.
- Reset asserted mid-RUN or in DONE aborts the operation immediately; no partial result is reported.

Test Plan:
- N=24, SEG=6; a=0xFFFFFF, b=0x000001, cin=0 -> out_valid exactly 4 edges after acceptance, s=0x000000, cout=1.
- a=0x123456, b=0x654321, cin=1 -> s=0x777778, cout=0; a, b changed to 0 one cycle after acceptance does not change the result.
- Cross-segment carry: a=0x00003F, b=0, cin=1 -> s=0x000040, cout=0. Also a=0x800000, b=0x800000 -> s=0, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid, s, cout stable; in_ready=0; no new capture. out_ready=1 -> IDLE on the next edge.
- Back-to-back: in_valid=1 and out_ready=1 continuously with changing operands -> one result every 6 cycles; every result matches a+b+cin.
- Reset mid-RUN, after 2 segments -> immediate in_ready=1, out_valid=0, s=0, cout=0, busy=0. The next transaction (0x000010+0x000020) gives s=0x000030.
- Random: 1000 operand sets, NSEG=1 (SEG=24) and NSEG=24 (SEG=1) builds -> all match the golden model with correct latency.
